// File: rtl/ir_remote_pkg.sv
// Shared types and constants for the NEC IR remote decoder.
// All timing windows are in microseconds, matching the phase counter's unit.
package ir_remote_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_CHECK,
        S_REPEAT,
        S_ERROR,
        S_WAIT_IDLE
    } ir_state_e;

    localparam logic [15:0] LEAD_MARK_MIN  = 16'd8000;
    localparam logic [15:0] LEAD_MARK_MAX  = 16'd10000;
    localparam logic [15:0] LEAD_SPACE_MIN = 16'd4000;
    localparam logic [15:0] LEAD_SPACE_MAX = 16'd5000;
    localparam logic [15:0] RPT_SPACE_MIN  = 16'd2000;
    localparam logic [15:0] RPT_SPACE_MAX  = 16'd2500;
    localparam logic [15:0] BIT_MARK_MIN   = 16'd400;
    localparam logic [15:0] BIT_MARK_MAX   = 16'd700;
    localparam logic [15:0] ZERO_SPACE_MIN = 16'd400;
    localparam logic [15:0] ZERO_SPACE_MAX = 16'd700;
    localparam logic [15:0] ONE_SPACE_MIN  = 16'd1400;
    localparam logic [15:0] ONE_SPACE_MAX  = 16'd1900;
    localparam logic [15:0] TIMEOUT_US     = 16'd12000;

    localparam logic [7:0] CMD_RESET     = 8'h45;
    localparam logic [7:0] CMD_PLAYPAUSE = 8'h40;
    localparam logic [7:0] CMD_RESTART   = 8'h44;
    localparam logic [7:0] CMD_FAST      = 8'h15;
    localparam logic [7:0] CMD_SLOW      = 8'h07;
    localparam logic [7:0] CMD_NEXT      = 8'h43;
    localparam logic [7:0] CMD_PREV      = 8'h09;

    function automatic logic in_win(input logic [15:0] v, input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Pulse vector order: reset, play/pause, restart, fast, slow, next, prev.
    function automatic logic [6:0] cmd_pulse(input logic [7:0] code);
        logic [6:0] p;
        p = '0;
        case (code)
            CMD_RESET:     p[0] = 1'b1;
            CMD_PLAYPAUSE: p[1] = 1'b1;
            CMD_RESTART:   p[2] = 1'b1;
            CMD_FAST:      p[3] = 1'b1;
            CMD_SLOW:      p[4] = 1'b1;
            CMD_NEXT:      p[5] = 1'b1;
            CMD_PREV:      p[6] = 1'b1;
            default:       p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ir_remote_decoder_timer.sv
// IR input conditioning: 2-flop synchronizer, edge detect, 1 us prescaler and
// a saturating microsecond counter that restarts on every line edge.
module ir_pulse_timer #(
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        rise_o,
    output logic        fall_o,
    output logic        level_o,
    output logic [15:0] phase_us_o
);
    localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);

    logic          sync1_q, sync2_q, prev_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   phase_q, phase_d;
    logic          tick;

    assign level_o    = sync2_q;
    assign rise_o     = ~prev_q & sync2_q;
    assign fall_o     = prev_q & ~sync2_q;
    assign phase_us_o = phase_q;
    assign tick       = (pre_q == PRE_MAX);

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        phase_d = phase_q;
        if (rise_o || fall_o)
            phase_d = '0;
        else if (tick && (phase_q != 16'hFFFF))
            phase_d = phase_q + 16'd1;
    end

    // Idle line is high, so the synchronizer resets high to avoid a false edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            pre_q   <= '0;
            phase_q <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pre_q   <= pre_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/ir_remote_decoder.sv
// NEC IR frame decoder producing one-cycle command pulses for the player.
// Define IR_REPEAT_EN to let repeat frames re-fire FAST/SLOW.
module ir_remote_decoder
    import ir_remote_pkg::*;
#(
    parameter int unsigned CLK_PER_US  = 50,
    parameter logic [7:0]  REMOTE_ADDR = 8'h00
) (
    input  logic       CLOCK,
    input  logic       Reset,
    input  logic       IR_RX,
    output logic       ResetRemote,
    output logic       PlayPauseRemote,
    output logic       RestartRemote,
    output logic       Fast,
    output logic       Slow,
    output logic       NextSongRemote,
    output logic       PrevSongRemote,
    output logic [7:0] cmd_code,
    output logic       frame_err
);
    logic        rise, fall, level;
    logic [15:0] phase_us;

    ir_pulse_timer #(.CLK_PER_US(CLK_PER_US)) u_timer (
        .clk_i      (CLOCK),
        .rst_i      (Reset),
        .rx_i       (IR_RX),
        .rise_o     (rise),
        .fall_o     (fall),
        .level_o    (level),
        .phase_us_o (phase_us)
    );

    ir_state_e   state_q;
    logic [31:0] sr_q;
    logic [4:0]  bit_idx_q;
    logic [7:0]  cmd_q;
    logic [6:0]  pulse_q;
    logic        err_q;
`ifdef IR_REPEAT_EN
    logic [7:0]  last_cmd_q;
    logic        last_valid_q;
`endif

    logic timeout, lead_mark_ok, lead_sp_ok, rpt_sp_ok, bit_mark_ok, zero_ok, one_ok, frame_ok;

    assign timeout      = phase_us >= TIMEOUT_US;
    assign lead_mark_ok = in_win(phase_us, LEAD_MARK_MIN, LEAD_MARK_MAX);
    assign lead_sp_ok   = in_win(phase_us, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
    assign rpt_sp_ok    = in_win(phase_us, RPT_SPACE_MIN, RPT_SPACE_MAX);
    assign bit_mark_ok  = in_win(phase_us, BIT_MARK_MIN, BIT_MARK_MAX);
    assign zero_ok      = in_win(phase_us, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
    assign one_ok       = in_win(phase_us, ONE_SPACE_MIN, ONE_SPACE_MAX);
    // Bits arrive LSB first: byte0 address, byte1 ~address, byte2 command, byte3 ~command.
    assign frame_ok     = (sr_q[7:0] == REMOTE_ADDR) && (sr_q[15:8] == ~sr_q[7:0]) &&
                          (sr_q[31:24] == ~sr_q[23:16]);

    // Edges are tested before timeouts so a coincident edge wins.
    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_idx_q <= '0;
            cmd_q     <= '0;
            pulse_q   <= '0;
            err_q     <= 1'b0;
`ifdef IR_REPEAT_EN
            last_cmd_q   <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            pulse_q <= '0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE:
                    if (fall) state_q <= S_LEAD_MARK;
                S_LEAD_MARK:
                    if (rise)         state_q <= lead_mark_ok ? S_LEAD_SPACE : S_ERROR;
                    else if (timeout) state_q <= S_ERROR;
                S_LEAD_SPACE:
                    if (fall) begin
                        bit_idx_q <= '0;
                        if (lead_sp_ok)     state_q <= S_BIT_MARK;
                        else if (rpt_sp_ok) state_q <= S_REPEAT;
                        else                state_q <= S_ERROR;
                    end else if (timeout) state_q <= S_ERROR;
                S_BIT_MARK:
                    if (rise)         state_q <= bit_mark_ok ? S_BIT_SPACE : S_ERROR;
                    else if (timeout) state_q <= S_ERROR;
                S_BIT_SPACE:
                    if (fall) begin
                        if (zero_ok || one_ok) begin
                            sr_q      <= {one_ok, sr_q[31:1]};
                            bit_idx_q <= bit_idx_q + 5'd1;
                            state_q   <= (bit_idx_q == 5'd31) ? S_CHECK : S_BIT_MARK;
                        end else begin
                            state_q <= S_ERROR;
                        end
                    end else if (timeout) state_q <= S_ERROR;
                S_CHECK:
                    if (frame_ok) begin
                        cmd_q   <= sr_q[23:16];
                        pulse_q <= cmd_pulse(sr_q[23:16]);
                        state_q <= S_WAIT_IDLE;
`ifdef IR_REPEAT_EN
                        last_cmd_q   <= sr_q[23:16];
                        last_valid_q <= 1'b1;
`endif
                    end else begin
                        state_q <= S_ERROR;
                    end
                S_REPEAT: begin
`ifdef IR_REPEAT_EN
                    if (last_valid_q && ((last_cmd_q == CMD_FAST) || (last_cmd_q == CMD_SLOW)))
                        pulse_q <= cmd_pulse(last_cmd_q);
`endif
                    state_q <= S_WAIT_IDLE;
                end
                S_ERROR: begin
                    err_q   <= 1'b1;
                    state_q <= S_WAIT_IDLE;
`ifdef IR_REPEAT_EN
                    last_valid_q <= 1'b0;
`endif
                end
                S_WAIT_IDLE:
                    if (level && timeout) state_q <= S_IDLE;
                default:
                    state_q <= S_IDLE;
            endcase
        end
    end

    assign ResetRemote     = pulse_q[0];
    assign PlayPauseRemote = pulse_q[1];
    assign RestartRemote   = pulse_q[2];
    assign Fast            = pulse_q[3];
    assign Slow            = pulse_q[4];
    assign NextSongRemote  = pulse_q[5];
    assign PrevSongRemote  = pulse_q[6];
    assign cmd_code        = cmd_q;
    assign frame_err       = err_q;

endmodule
